// File: rtl/reg_file_mp.sv
// Multi-ported register file: two write ports, NUM_RD combinational read
// ports, and the top register serving as an auto-incrementing PC.
module reg_file_mp #(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 4,
    parameter int NUM_RD       = 3,
    parameter int PC_STEP      = 4,
    parameter int PC_RD_OFFSET = 8,
    parameter int RESET_PC     = 0,
    parameter int BYPASS       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     pc_inc,
    output logic [DATA_W-1:0]        pc,
    output logic                     conflict
);

    localparam int                PC_IDX  = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] RD_OFF  = DATA_W'(PC_RD_OFFSET);
    localparam logic [DATA_W-1:0] STEP    = DATA_W'(PC_STEP);

    logic [DATA_W-1:0] gpr_q [PC_IDX];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              conflict_q, conflict_d;
    logic              wa_ok, wb_ok;

    assign wa_ok = wa_en && (32'(wa_addr) < NUM_REGS);
    assign wb_ok = wb_en && (32'(wb_addr) < NUM_REGS);

    assign conflict_d = wa_ok && wb_ok && (wa_addr == wb_addr);

    always_comb begin
        pc_d = pc_q;
        if (wa_ok && wa_addr == PC_ADDR)
            pc_d = wa_data;
        else if (wb_ok && wb_addr == PC_ADDR)
            pc_d = wb_data;
        else if (pc_inc)
            pc_d = pc_q + STEP;
    end

    // Port A wins over port B on a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PC_IDX; i++)
                gpr_q[i] <= '0;
            pc_q       <= DATA_W'(RESET_PC);
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < PC_IDX; i++) begin
                if (wa_ok && wa_addr == ADDR_W'(i))
                    gpr_q[i] <= wa_data;
                else if (wb_ok && wb_addr == ADDR_W'(i))
                    gpr_q[i] <= wb_data;
            end
            pc_q       <= pc_d;
            conflict_q <= conflict_d;
        end
    end

    // Writes are inert in reset, so forwarding is suppressed there too.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] v;
            a = rd_addr[p*ADDR_W +: ADDR_W];
            v = '0;
            for (int i = 0; i < PC_IDX; i++)
                if (a == ADDR_W'(i))
                    v = gpr_q[i];
            if (a == PC_ADDR)
                v = pc_q + RD_OFF;
            if (BYPASS != 0 && reset) begin
                if (wa_ok && wa_addr == a)
                    v = (a == PC_ADDR) ? wa_data + RD_OFF : wa_data;
                else if (wb_ok && wb_addr == a)
                    v = (a == PC_ADDR) ? wb_data + RD_OFF : wb_data;
            end
            rd_data[p*DATA_W +: DATA_W] = v;
        end
    end

    assign pc       = pc_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default, non-bypass and 8-register
// instances driven with hand-computed vectors.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic        wa_en, wb_en, pc_inc;
    logic [3:0]  wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;
    logic [11:0] rd_addr;
    logic [95:0] rd_data, rd_data_nb;
    logic [31:0] pc, pc_nb;
    logic        conflict, conflict_nb;

    logic        p_wa_en, p_wb_en, p_pc_inc;
    logic [3:0]  p_wa_addr, p_wb_addr;
    logic [31:0] p_wa_data, p_wb_data;
    logic [15:0] p_rd_addr;
    logic [127:0] p_rd_data;
    logic [31:0] p_pc;
    logic        p_conflict;

    int checks = 0;
    int errors = 0;

    reg_file_mp dut (
        .clk(clk), .reset(reset),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .pc_inc(pc_inc), .pc(pc), .conflict(conflict)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .pc_inc(pc_inc), .pc(pc_nb), .conflict(conflict_nb)
    );

    reg_file_mp #(.NUM_REGS(8), .ADDR_W(4), .NUM_RD(4)) dut8 (
        .clk(clk), .reset(reset),
        .wa_en(p_wa_en), .wa_addr(p_wa_addr), .wa_data(p_wa_data),
        .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .pc_inc(p_pc_inc), .pc(p_pc), .conflict(p_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wa_en;
        logic [3:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic        pc_inc;
        logic [3:0]  r0, r1, r2;
        logic [31:0] e0, e1, e2;
        logic [31:0] epc;
        logic        econf;
    } vec_t;

    vec_t vec [18];

    function automatic logic [31:0] rd(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rdnb(input int p);
        return rd_data_nb[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rd8(input int p);
        return p_rd_data[p*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        pc_inc = 0;
        p_wa_en = 0; p_wa_addr = 0; p_wa_data = 0;
        p_wb_en = 0; p_wb_addr = 0; p_wb_data = 0;
        p_pc_inc = 0;
    endtask

    initial begin
        // wa_en,wa_addr,wa_data, wb_en,wb_addr,wb_data, pc_inc,
        // r0,r1,r2, e0,e1,e2, epc, econf
        vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 15, 3,
                    0, 8, 0, 0, 0};
        vec[1]  = '{1, 3, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 3, 7, 1,
                    32'hDEADBEEF, 32'h12345678, 0, 0, 0};
        vec[2]  = '{0, 0, 0, 0, 0, 0, 0, 3, 7, 15,
                    32'hDEADBEEF, 32'h12345678, 8, 0, 0};
        vec[3]  = '{1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 5, 5, 3,
                    32'h11111111, 32'h11111111, 32'hDEADBEEF, 0, 0};
        vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 5, 7, 0,
                    32'h11111111, 32'h12345678, 0, 0, 1};
        vec[5]  = '{0, 0, 0, 0, 0, 0, 0, 5, 3, 7,
                    32'h11111111, 32'hDEADBEEF, 32'h12345678, 0, 0};
        vec[6]  = '{1, 15, 32'hFFFFFFFC, 0, 0, 0, 0, 15, 15, 2,
                    4, 4, 0, 0, 0};
        vec[7]  = '{0, 0, 0, 0, 0, 0, 1, 15, 0, 5,
                    4, 0, 32'h11111111, 32'hFFFFFFFC, 0};
        vec[8]  = '{1, 15, 32'h100, 0, 0, 0, 1, 15, 15, 3,
                    32'h108, 32'h108, 32'hDEADBEEF, 0, 0};
        vec[9]  = '{0, 0, 0, 0, 0, 0, 0, 15, 0, 0,
                    32'h108, 0, 0, 32'h100, 0};
        vec[10] = '{0, 0, 0, 1, 15, 32'h200, 1, 15, 15, 15,
                    32'h208, 32'h208, 32'h208, 32'h100, 0};
        vec[11] = '{0, 0, 0, 0, 0, 0, 1, 15, 2, 0,
                    32'h208, 0, 0, 32'h200, 0};
        vec[12] = '{1, 2, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 2, 2,
                    0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h204, 0};
        vec[13] = '{1, 4, 6, 1, 2, 5, 0, 2, 4, 2,
                    5, 6, 5, 32'h204, 0};
        vec[14] = '{0, 0, 0, 0, 0, 0, 0, 2, 4, 3,
                    5, 6, 32'hDEADBEEF, 32'h204, 0};
        vec[15] = '{1, 15, 32'h300, 1, 15, 32'h400, 0, 15, 14, 15,
                    32'h308, 0, 32'h308, 32'h204, 0};
        vec[16] = '{0, 0, 0, 0, 0, 0, 0, 15, 5, 7,
                    32'h308, 32'h11111111, 32'h12345678, 32'h300, 1};
        vec[17] = '{0, 0, 0, 0, 0, 0, 0, 15, 3, 4,
                    32'h308, 32'hDEADBEEF, 6, 32'h300, 0};

        reset = 0;
        idle();
        rd_addr = 0;
        p_rd_addr = {4'd12, 4'd3, 4'd7, 4'd12};

        // reset state, read mid-cycle while reset is low
        #12;
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'd0, 4'd0, 4'(i)};
            #1;
            chk($sformatf("rst r%0d", i), rd(0), (i == 15) ? 32'h8 : 32'h0);
        end
        chk("rst pc", pc, 0);
        chk("rst conflict", {31'b0, conflict}, 0);
        chk("rst p r12", rd8(0), 0);
        chk("rst p r7", rd8(1), 8);

        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            wa_en = vec[i].wa_en; wa_addr = vec[i].wa_addr;
            wa_data = vec[i].wa_data;
            wb_en = vec[i].wb_en; wb_addr = vec[i].wb_addr;
            wb_data = vec[i].wb_data;
            pc_inc = vec[i].pc_inc;
            rd_addr = {vec[i].r2, vec[i].r1, vec[i].r0};
            #2;
            chk($sformatf("v%0d rd0", i), rd(0), vec[i].e0);
            chk($sformatf("v%0d rd1", i), rd(1), vec[i].e1);
            chk($sformatf("v%0d rd2", i), rd(2), vec[i].e2);
            chk($sformatf("v%0d pc", i), pc, vec[i].epc);
            chk($sformatf("v%0d conflict", i),
                {31'b0, conflict}, {31'b0, vec[i].econf});
        end

        // BYPASS=0 returns stored contents during a write
        @(negedge clk);
        idle();
        wa_en = 1; wa_addr = 2; wa_data = 32'h77;
        rd_addr = {4'd15, 4'd2, 4'd4};
        #2;
        chk("byp rd1", rd(1), 32'h77);
        chk("nobyp rd1 old", rdnb(1), 5);
        chk("nobyp pc read", rdnb(2), 32'h308);
        @(negedge clk);
        idle();
        #2;
        chk("nobyp rd1 new", rdnb(1), 32'h77);
        chk("nobyp rd0", rdnb(0), 6);

        // 8-register instance: out-of-range address, PC at r7
        @(negedge clk);
        p_wa_en = 1; p_wa_addr = 12; p_wa_data = 32'hBAD;
        p_rd_addr = {4'd12, 4'd3, 4'd7, 4'd12};
        #2;
        chk("p bad byp", rd8(0), 0);
        chk("p pc rd", rd8(1), 8);
        @(negedge clk);
        idle();
        #2;
        chk("p bad rd", rd8(0), 0);
        chk("p bad rd3", rd8(3), 0);
        chk("p pc", p_pc, 0);
        chk("p r3", rd8(2), 0);
        @(negedge clk);
        p_wa_en = 1; p_wa_addr = 7; p_wa_data = 32'h40;
        p_wb_en = 1; p_wb_addr = 3; p_wb_data = 32'h33;
        #2;
        chk("p pc byp", rd8(1), 32'h48);
        chk("p r3 byp", rd8(2), 32'h33);
        @(negedge clk);
        idle();
        #2;
        chk("p pc wr", p_pc, 32'h40);
        chk("p pc rd2", rd8(1), 32'h48);
        chk("p r3 wr", rd8(2), 32'h33);
        chk("p conflict", {31'b0, p_conflict}, 0);

        // reset asserted mid-cycle with writes and pc_inc pending
        @(negedge clk);
        wa_en = 1; wa_addr = 3; wa_data = 32'h99;
        wb_en = 1; wb_addr = 3; wb_data = 32'h66;
        pc_inc = 1;
        rd_addr = {4'd15, 4'd6, 4'd3};
        #2;
        reset = 0;
        #1;
        chk("mid r3", rd(0), 0);
        chk("mid r6", rd(1), 0);
        chk("mid r15", rd(2), 8);
        chk("mid pc", pc, 0);
        chk("mid conflict", {31'b0, conflict}, 0);
        @(posedge clk);
        #1;
        chk("mid edge r3", rd(0), 0);
        chk("mid edge pc", pc, 0);
        chk("mid edge conflict", {31'b0, conflict}, 0);
        chk("mid p pc", p_pc, 0);

        @(negedge clk);
        idle();
        reset = 1;
        wa_en = 1; wa_addr = 3; wa_data = 32'h55;
        #2;
        chk("post byp r3", rd(0), 32'h55);
        @(negedge clk);
        idle();
        #2;
        chk("post r3", rd(0), 32'h55);
        chk("post pc", pc, 0);
        chk("post conflict", {31'b0, conflict}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
